// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ID/EX ALU control stage: widened ALU codes,
// funct7 encodings and the multiply/divide sequencer states.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_MD   = 4'b1111;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode-in / control-out bundle between the ID stage, alu_ctrl_seq and EX.
interface alu_ctrl_seq_if #(
    parameter int CTRL_W = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              opb5;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [1:0]        ALUOp;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ALUControl;
    logic [2:0]        md_op;
    logic              md_start;
    logic              md_busy;
    logic              illegal;

    modport master (
        output flush, in_valid, opb5, funct3, funct7, ALUOp, out_ready,
        input  in_ready, out_valid, ALUControl, md_op, md_start, md_busy, illegal
    );

    modport slave (
        input  flush, in_valid, opb5, funct3, funct7, ALUOp, out_ready,
        output in_ready, out_valid, ALUControl, md_op, md_start, md_busy, illegal
    );
endinterface

// File: rtl/md_latency_seq.sv
// Multiply/divide latency sequencer: holds the front end off until the
// selected MD latency has elapsed and the result has been consumed.
//   state | meaning
//   IDLE  | no M op in flight
//   BUSY  | M op launched, counting down remaining latency
//   DONE  | latency elapsed, result presented until out_ready
module md_latency_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic lat_sel,
    input  logic flush,
    input  logic out_ready,
    output logic busy,
    output logic done,
    output logic md_start
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load;
    logic             md_start_q, md_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_start_d = 1'b0;
        load       = lat_sel ? DIV_LOAD : MUL_LOAD;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    md_start_d = 1'b1;
                    cnt_d      = load;
                    state_d    = (load == '0) ? DONE : BUSY;
                end
                BUSY: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            md_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign md_start = md_start_q;

endmodule

// File: rtl/alu_ctrl_seq.sv
// ID/EX ALU control stage: decodes ALUOp/funct3/funct7/opb5 into a widened
// ALU code, registers it, and sequences RV32M ops through md_latency_seq.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter bit EN_M    = 1'b1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus
);
    logic [3:0]        code;
    logic              dec_illegal;
    logic              dec_md;
    logic              is_r;
    logic              accept;
    logic              md_busy;
    logic              md_done;
    logic              out_valid;
    logic              nm_valid_q, nm_valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [2:0]        md_op_q, md_op_d;
    logic              illegal_q, illegal_d;

    always_comb begin
        code        = ALU_ADD;
        dec_illegal = 1'b0;
        dec_md      = 1'b0;
        is_r        = (bus.ALUOp == 2'b10) && bus.opb5;
        case (bus.ALUOp)
            2'b00: code = ALU_ADD;
            2'b01: code = ALU_SUB;
            2'b11: dec_illegal = 1'b1;
            default: begin
                if (is_r && (bus.funct7 == FUNCT7_MULDIV) && EN_M) begin
                    dec_md = 1'b1;
                    code   = ALU_MD;
                end else if (is_r && (bus.funct7 != FUNCT7_BASE) && (bus.funct7 != FUNCT7_ALT)) begin
                    dec_illegal = 1'b1;
                end else begin
                    case (bus.funct3)
                        3'b000:  code = (bus.funct7[5] && bus.opb5) ? ALU_SUB : ALU_ADD;
                        3'b001:  code = ALU_SLL;
                        3'b010:  code = ALU_SLT;
                        3'b011:  code = ALU_SLTU;
                        3'b100:  code = ALU_XOR;
                        3'b101:  code = bus.funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end
            end
        endcase
    end

    // An M result is presented by the sequencer's DONE state, not by nm_valid_q.
    assign out_valid    = nm_valid_q | md_done;
    assign bus.in_ready = ~md_busy & (~out_valid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

    always_comb begin
        nm_valid_d = nm_valid_q;
        ctrl_d     = ctrl_q;
        md_op_d    = md_op_q;
        illegal_d  = illegal_q;
        if (bus.flush) begin
            nm_valid_d = 1'b0;
        end else if (accept) begin
            nm_valid_d  = ~dec_md;
            ctrl_d      = '0;
            ctrl_d[3:0] = code;
            md_op_d     = dec_md ? bus.funct3 : 3'b000;
            illegal_d   = dec_illegal;
        end else if (bus.out_ready) begin
            nm_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nm_valid_q <= 1'b0;
            ctrl_q     <= '0;
            md_op_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            nm_valid_q <= nm_valid_d;
            ctrl_q     <= ctrl_d;
            md_op_q    <= md_op_d;
            illegal_q  <= illegal_d;
        end
    end

    md_latency_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept & dec_md),
        .lat_sel   (bus.funct3[2]),
        .flush     (bus.flush),
        .out_ready (bus.out_ready),
        .busy      (md_busy),
        .done      (md_done),
        .md_start  (bus.md_start)
    );

    assign bus.out_valid  = out_valid;
    assign bus.ALUControl = ctrl_q;
    assign bus.md_op      = md_op_q;
    assign bus.md_busy    = md_busy;
    assign bus.illegal    = illegal_q;

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised ALU control stage for the pipelined RV32 core, placed at the ID/EX boundary. It decodes ALUOp/funct3/funct7/opb5 into a widened ALU control code, separating ops the 3-bit scheme merged: sra vs srl and sltu vs slt. It also adds RV32M. Multiply/divide ops go through a latency-sequencing FSM that back-pressures the front end with a valid/ready handshake until the configured MD latency has elapsed.

## Interface
- `CTRL_W`, 4: ALUControl width; legal values are >= 4, with upper bits zero.
- `EN_M`, 1: when 1, RV32M is decoded; when 0, funct7 = 0000001 is flagged illegal.
- `MUL_LAT`, 2: multiply latency in cycles; legal values are >= 1.
- `DIV_LAT`, 32: divide/remainder latency in cycles; legal values are >= 1.
- `clk` in, 1: the single clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `flush` in, 1: synchronous kill with the highest priority.
- `in_valid` in, 1: the decode fields are valid.
- `in_ready` out, 1: the block accepts a decode this cycle.
- `opb5` in, 1: opcode bit 5 (R-type = 1).
- `funct3` in, 3.
- `funct7` in, 7.
- `ALUOp` in, 2.
- `out_valid` out, 1: the registered result is valid.
- `out_ready` in, 1: EX consumes the result.
- `ALUControl` out, CTRL_W.
- `md_op` out, 3: the funct3 of the M op; 0 otherwise.
- `md_start` out, 1: one-cycle pulse that launches the MD unit.
- `md_busy` out, 1: an M op is in flight.
- `illegal` out, 1: the decode is unsupported and travels with out_valid.

## Operation
- Codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt, 0110 srl, 0111 xor, 1000 sra, 1001 sltu, 1111 md (result taken from the MD unit). Codes 0000–0111 keep their legacy meaning.
- ALUOp 00 decodes to add; ALUOp 01 decodes to sub.
- ALUOp 11 is illegal: illegal = 1 and ALUControl = 0.
- ALUOp 10, funct3 000: sub when funct7[5] & opb5, else add.
- ALUOp 10, funct3 101: sra when funct7[5], else srl. opb5 is ignored here, which covers srai.
- ALUOp 10, funct3 010 decodes to slt; funct3 011 decodes to sltu.
- Remaining funct3 values map as follows: 001 sll, 100 xor, 110 or, 111 and.
- An M op is ALUOp 10 & opb5 & funct7 = 0000001 & EN_M. It decodes to ALUControl = 1111 and md_op = funct3.
- M-op latency is MUL_LAT when funct3[2] = 0 and DIV_LAT when funct3[2] = 1.
- R-type (ALUOp 10, opb5 = 1) with any funct7 other than 0000000, 0100000, or an enabled 0000001 is illegal.
- FSM states:
  - IDLE → BUSY when an M op is accepted and its latency is > 1.
  - IDLE → DONE when an M op is accepted and its latency is 1.
  - BUSY → DONE when the counter reaches 0.
  - DONE → IDLE when out_ready is high.
- Counter width is $clog2(max(MUL_LAT, DIV_LAT)+1). It is loaded with latency−1 on accept and decremented in BUSY.
- Handshake and outputs:
  - in_ready = (state == IDLE) & (~out_valid | out_ready).
  - A non-M accept updates the output register on the next edge.
  - out_valid stays high, with its payload stable, until out_ready.
  - md_busy is 1 in BUSY and DONE.
  - md_start is 1 only in the first cycle after an M accept.
- flush: on the next edge out_valid = 0, state = IDLE, the counter clears and md_start is suppressed. in_valid is ignored during a flush cycle.

## Timing
- Reset (async assert, sync release): out_valid, ALUControl, md_op, md_start, md_busy and illegal are all 0. State is IDLE, the counter is 0 and in_ready = 1.
- Non-M op accepted at edge N: out_valid appears in cycle N+1. Back-to-back throughput is one per cycle while out_ready = 1.
- M op accepted at edge N:
  - md_start is high in cycle N+1.
  - The block is in BUSY for cycles N+1 … N+LAT−1 and in DONE from N+LAT, with out_valid = 1 in DONE.
  - in_ready is 0 from N+1 until the cycle after DONE completes.
- out_ready low on a valid result: all outputs hold and in_ready = 0.
- flush together with in_valid: nothing is accepted.
- flush in BUSY: the in-flight op is aborted, and in_ready = 1 the following cycle.
- rst_n asserted mid-operation: state clears immediately, with no md_start glitch.

## Structure
- Package `alu_ctrl_pkg`: ALU code localparams (4-bit, zero-extended to CTRL_W), the FSM state enum (IDLE, BUSY, DONE), and the FUNCT7_BASE/ALT/MULDIV constants.
- Sub-module `md_latency_seq`: FSM plus counter, with inputs start/lat_sel/flush/out_ready and outputs busy/done/md_start.
- Top level: combinational decode and the output register.

## Test plan
- Reset, then ALUOp = 10, funct3 = 101, funct7 = 0100000, opb5 = 0 (srai) → next cycle ALUControl = 1000, out_valid = 1, illegal = 0.
- ALUOp = 10, funct3 = 011 → 1001. ALUOp = 10, funct3 = 000, opb5 = 1, funct7 = 0100000 → 0001. ALUOp = 10, funct3 = 000, opb5 = 0, funct7 = 0100000 → 0000.
- mul (funct7 = 0000001, funct3 = 000) with MUL_LAT = 2 → md_start at N+1, out_valid at N+2 with ALUControl = 1111 and md_op = 000, in_ready low for N+1..N+2.
- div (funct3 = 100) with DIV_LAT = 32, flush at N+10 → out_valid never rises, md_busy = 0 at N+11, next add accepted.
- out_ready held low for 3 cycles on a valid add → payload stable, in_ready = 0. ALUOp = 11 → illegal = 1, ALUControl = 0.
- EN_M = 0 with funct7 = 0000001 and opb5 = 1 → illegal = 1, no md_start. rst_n pulsed in BUSY → all outputs 0 asynchronously.
